// File: rtl/seq_pkg.sv
// Shared definitions for the sequence tracker: the producer's 16-entry code
// sequence, code-to-position match helper and mask rotation helpers.
package seq_pkg;

  localparam int unsigned SEQ_LEN = 16;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned IDX_W   = 4;

  localparam logic [SEQ_LEN-1:0] CAND_ALL = 16'hFFFF;

  localparam logic [CODE_W-1:0] SEQ [SEQ_LEN] = '{
    4'h5, 4'hC, 4'h0, 4'h8, 4'h6, 4'h8, 4'h5, 4'hF,
    4'h9, 4'hD, 4'h9, 4'hE, 4'hC, 4'h7, 4'hF, 4'hC
  };

  // Bit p set when the producer at position p would emit this code.
  function automatic logic [SEQ_LEN-1:0] code_match(input logic [CODE_W-1:0] code);
    logic [SEQ_LEN-1:0] m;
    m = '0;
    for (int unsigned p = 0; p < SEQ_LEN; p++) begin
      m[p] = (SEQ[p] == code);
    end
    return m;
  endfunction

  // Bit p of the result takes bit p-1 of the input (wrapping).
  function automatic logic [SEQ_LEN-1:0] rot_from_below(input logic [SEQ_LEN-1:0] m);
    return {m[SEQ_LEN-2:0], m[SEQ_LEN-1]};
  endfunction

  // Bit p of the result takes bit p+1 of the input (wrapping).
  function automatic logic [SEQ_LEN-1:0] rot_from_above(input logic [SEQ_LEN-1:0] m);
    return {m[0], m[SEQ_LEN-1:1]};
  endfunction

endpackage

// File: rtl/seq_onehot_enc.sv
// Combinational 16-bit mask encoder: index of the set bit plus a one-hot flag.
module seq_onehot_enc
  import seq_pkg::*;
(
  input  logic [SEQ_LEN-1:0] mask,
  output logic [IDX_W-1:0]   idx_c,
  output logic               onehot_c
);

  // OR of set-bit positions; only meaningful when exactly one bit is set.
  always_comb begin
    idx_c = '0;
    for (int unsigned p = 0; p < SEQ_LEN; p++) begin
      if (mask[p]) idx_c = idx_c | IDX_W'(p);
    end
    onehot_c = ($countones(mask) == 1);
  end

endmodule

// File: rtl/seq_tracker.sv
// Observer-side tracker: follows the producer's position in the 16-entry
// code sequence, reports lock, step direction and inconsistent samples.
module seq_tracker
  import seq_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               VALID,
  input  logic [CODE_W-1:0]  CODE_I,
  input  logic               SYNC,
  output logic [IDX_W-1:0]   INDEX,
  output logic               LOCK,
  output logic               DIR,
  output logic               ERR,
  output logic [SEQ_LEN-1:0] CAND
);

  logic [SEQ_LEN-1:0] match_c;
  logic [SEQ_LEN-1:0] base_c;
  logic [SEQ_LEN-1:0] nxt_c;
  logic [SEQ_LEN-1:0] cand_d;
  logic               err_d;
  logic               dir_d;
  logic [IDX_W-1:0]   q_c;
  logic               onehot_c;

  // Candidate update; an empty mask behaves like a fresh start.
  always_comb begin
    match_c = code_match(CODE_I);
    base_c  = (CAND == '0) ? CAND_ALL : CAND;
    nxt_c   = match_c & (base_c | rot_from_below(base_c) | rot_from_above(base_c));
    cand_d  = CAND;
    err_d   = 1'b0;
    if (SYNC) begin
      cand_d = VALID ? match_c : CAND_ALL;
    end else if (VALID) begin
      if (nxt_c != '0) begin
        cand_d = nxt_c;
      end else begin
        cand_d = match_c;
        err_d  = 1'b1;
      end
    end
  end

  seq_onehot_enc u_enc (
    .mask     (cand_d),
    .idx_c    (q_c),
    .onehot_c (onehot_c)
  );

  // Direction from where the new single position sat in the old mask.
  always_comb begin
    dir_d = DIR;
    if (onehot_c && !CAND[q_c]) begin
      if (CAND[IDX_W'(q_c - IDX_W'(1))])      dir_d = 1'b1;
      else if (CAND[IDX_W'(q_c + IDX_W'(1))]) dir_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CAND  <= CAND_ALL;
      LOCK  <= 1'b0;
      INDEX <= '0;
      DIR   <= 1'b1;
      ERR   <= 1'b0;
    end else begin
      CAND <= cand_d;
      ERR  <= err_d;
      LOCK <= onehot_c;
      DIR  <= dir_d;
      if (onehot_c) INDEX <= q_c;
    end
  end

endmodule

// File: tb/tb_seq_tracker.sv
// Self-checking bench for seq_tracker: directed scenarios plus a randomized
// producer walk compared against a position-set reference model.
module tb_seq_tracker;

  logic       CLK;
  logic       RST;
  logic       VALID;
  logic [3:0] CODE_I;
  logic       SYNC;
  logic [3:0] INDEX;
  logic       LOCK;
  logic       DIR;
  logic       ERR;
  logic [15:0] CAND;

  int checks = 0;
  int errors = 0;

  logic [3:0] tseq [16] = '{4'h5, 4'hC, 4'h0, 4'h8, 4'h6, 4'h8, 4'h5, 4'hF,
                            4'h9, 4'hD, 4'h9, 4'hE, 4'hC, 4'h7, 4'hF, 4'hC};

  // Reference model state
  bit       m_pos [16];
  bit       m_lock;
  int       m_index;
  bit       m_dir;
  bit       m_err;

  seq_tracker dut (
    .CLK    (CLK),
    .RST    (RST),
    .VALID  (VALID),
    .CODE_I (CODE_I),
    .SYNC   (SYNC),
    .INDEX  (INDEX),
    .LOCK   (LOCK),
    .DIR    (DIR),
    .ERR    (ERR),
    .CAND   (CAND)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic v, input logic s, input logic [3:0] c);
    VALID = v; SYNC = s; CODE_I = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    VALID = 1'b0; SYNC = 1'b0; CODE_I = 4'h0;
    #2 RST = 1'b0;
    #7 RST = 1'b1;
    @(posedge CLK);
    #1;
    for (int p = 0; p < 16; p++) m_pos[p] = 1'b1;
    m_lock = 0; m_index = 0; m_dir = 1; m_err = 0;
  endtask

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    for (int p = 0; p < 16; p++) m[p] = m_pos[p];
    return m;
  endfunction

  // Advance the model by one edge using the position-set rules.
  function automatic void model_step(input bit v, input bit s, input logic [3:0] c);
    bit old [16];
    bit nw [16];
    bit any_old, any_new;
    int cnt, q;
    any_old = 0;
    for (int p = 0; p < 16; p++) begin old[p] = m_pos[p]; any_old |= old[p]; end
    m_err = 0;
    if (!v && !s) return;
    any_new = 0;
    for (int p = 0; p < 16; p++) begin
      bit here, near;
      here = (tseq[p] == c);
      near = !any_old || old[p] || old[(p + 15) % 16] || old[(p + 1) % 16];
      if (s) nw[p] = v ? here : 1'b1;
      else   nw[p] = here && near;
      any_new |= nw[p];
    end
    if (!s && !any_new) begin
      m_err = 1;
      for (int p = 0; p < 16; p++) nw[p] = (tseq[p] == c);
    end
    cnt = 0; q = 0;
    for (int p = 0; p < 16; p++) if (nw[p]) begin cnt++; q = p; end
    m_lock = (cnt == 1);
    if (cnt == 1) begin
      m_index = q;
      if (!old[q]) begin
        if (old[(q + 15) % 16])     m_dir = 1;
        else if (old[(q + 1) % 16]) m_dir = 0;
      end
    end
    for (int p = 0; p < 16; p++) m_pos[p] = nw[p];
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (CAND !== 16'hFFFF) begin errors++; $display("FAIL reset_cand got %h want ffff", CAND); end
    checks++; if (LOCK !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", LOCK); end
    checks++; if (INDEX !== 4'd0) begin errors++; $display("FAIL reset_index got %0d want 0", INDEX); end
    checks++; if (DIR !== 1'b1) begin errors++; $display("FAIL reset_dir got %b want 1", DIR); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ERR); end
  endtask

  task automatic test_acquire();
    do_reset();
    drive(1, 0, 4'h5);
    checks++; if (CAND !== 16'h0041) begin errors++; $display("FAIL acq_cand1 got %h want 0041", CAND); end
    checks++; if (LOCK !== 1'b0) begin errors++; $display("FAIL acq_lock1 got %b want 0", LOCK); end
    drive(1, 0, 4'hC);
    checks++; if (CAND !== 16'h8002) begin errors++; $display("FAIL acq_cand2 got %h want 8002", CAND); end
    drive(1, 0, 4'h0);
    checks++; if (CAND !== 16'h0004) begin errors++; $display("FAIL acq_cand3 got %h want 0004", CAND); end
    checks++; if (LOCK !== 1'b1 || INDEX !== 4'd2 || DIR !== 1'b1) begin
      errors++; $display("FAIL acq_lock got lock=%b idx=%0d dir=%b want 1/2/1", LOCK, INDEX, DIR);
    end
  endtask

  task automatic test_down();
    do_reset();
    drive(1, 0, 4'h5); drive(1, 0, 4'hC); drive(1, 0, 4'hF);
    checks++; if (LOCK !== 1'b1 || INDEX !== 4'd14 || DIR !== 1'b0) begin
      errors++; $display("FAIL down_lock got lock=%b idx=%0d dir=%b want 1/14/0", LOCK, INDEX, DIR);
    end
    drive(1, 0, 4'hF);
    checks++; if (INDEX !== 4'd14 || ERR !== 1'b0) begin
      errors++; $display("FAIL down_hold got idx=%0d err=%b want 14/0", INDEX, ERR);
    end
    drive(1, 0, 4'h7);
    checks++; if (INDEX !== 4'd13 || DIR !== 1'b0 || ERR !== 1'b0 || CAND !== 16'h2000) begin
      errors++; $display("FAIL down_step got idx=%0d dir=%b err=%b cand=%h want 13/0/0/2000", INDEX, DIR, ERR, CAND);
    end
  endtask

  task automatic test_hold_step();
    test_acquire();
    drive(1, 0, 4'h0);
    drive(1, 0, 4'h0);
    checks++; if (INDEX !== 4'd2 || LOCK !== 1'b1 || ERR !== 1'b0) begin
      errors++; $display("FAIL hold got idx=%0d lock=%b err=%b want 2/1/0", INDEX, LOCK, ERR);
    end
    drive(1, 0, 4'h8);
    checks++; if (INDEX !== 4'd3 || DIR !== 1'b1 || ERR !== 1'b0 || CAND !== 16'h0008) begin
      errors++; $display("FAIL step_up got idx=%0d dir=%b err=%b cand=%h want 3/1/0/0008", INDEX, DIR, ERR, CAND);
    end
  endtask

  task automatic test_jump();
    test_acquire();
    drive(1, 0, 4'hD);
    checks++; if (ERR !== 1'b1 || CAND !== 16'h0200 || INDEX !== 4'd9 || LOCK !== 1'b1 || DIR !== 1'b1) begin
      errors++; $display("FAIL jump got err=%b cand=%h idx=%0d lock=%b dir=%b want 1/0200/9/1/1", ERR, CAND, INDEX, LOCK, DIR);
    end
    drive(0, 0, 4'h0);
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL jump_err_pulse got %b want 0", ERR); end
    // Jump from a down-locked state must keep DIR=0
    do_reset();
    drive(1, 0, 4'h5); drive(1, 0, 4'hC); drive(1, 0, 4'hF);
    drive(1, 0, 4'hD);
    checks++; if (ERR !== 1'b1 || INDEX !== 4'd9 || DIR !== 1'b0) begin
      errors++; $display("FAIL jump_dir got err=%b idx=%0d dir=%b want 1/9/0", ERR, INDEX, DIR);
    end
  endtask

  task automatic test_illegal();
    test_acquire();
    drive(1, 0, 4'hA);
    checks++; if (ERR !== 1'b1 || CAND !== 16'h0000 || LOCK !== 1'b0 || INDEX !== 4'd2) begin
      errors++; $display("FAIL illegal got err=%b cand=%h lock=%b idx=%0d want 1/0000/0/2", ERR, CAND, LOCK, INDEX);
    end
    drive(1, 0, 4'hE);
    checks++; if (CAND !== 16'h0800 || INDEX !== 4'd11 || LOCK !== 1'b1 || ERR !== 1'b0) begin
      errors++; $display("FAIL relock got cand=%h idx=%0d lock=%b err=%b want 0800/11/1/0", CAND, INDEX, LOCK, ERR);
    end
  endtask

  task automatic test_sync();
    test_acquire();
    drive(0, 1, 4'h3);
    checks++; if (CAND !== 16'hFFFF || LOCK !== 1'b0 || ERR !== 1'b0 || INDEX !== 4'd2) begin
      errors++; $display("FAIL sync_idle got cand=%h lock=%b err=%b idx=%0d want ffff/0/0/2", CAND, LOCK, ERR, INDEX);
    end
    drive(1, 0, 4'h0);
    drive(1, 1, 4'hD);
    checks++; if (CAND !== 16'h0200 || ERR !== 1'b0 || INDEX !== 4'd9) begin
      errors++; $display("FAIL sync_valid got cand=%h err=%b idx=%0d want 0200/0/9", CAND, ERR, INDEX);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 4'h5); drive(1, 0, 4'hC); drive(1, 0, 4'hF);
    drive(1, 0, 4'hA);
    #2 RST = 1'b0;
    #1;
    checks++; if (CAND !== 16'hFFFF || LOCK !== 1'b0 || INDEX !== 4'd0 || DIR !== 1'b1 || ERR !== 1'b0) begin
      errors++; $display("FAIL reset_mid got cand=%h lock=%b idx=%0d dir=%b err=%b", CAND, LOCK, INDEX, DIR, ERR);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    int pos, r;
    bit v, s;
    logic [3:0] c;
    do_reset();
    pos = $urandom_range(0, 15);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      v = 1; s = 0;
      if (r < 10)      v = 0;
      else if (r < 13) begin s = 1; v = $urandom_range(0, 1); end
      else if (r < 50) ;
      else if (r < 75) pos = (pos + 1) % 16;
      else if (r < 90) pos = (pos + 15) % 16;
      else if (r < 95) pos = $urandom_range(0, 15);
      c = tseq[pos];
      if (r >= 95) c = 4'($urandom_range(0, 15));
      drive(v, s, c);
      model_step(v, s, c);
      checks++; if (CAND !== model_mask()) begin errors++; $display("FAIL rnd_cand cyc %0d got %h want %h", i, CAND, model_mask()); end
      checks++; if (LOCK !== m_lock) begin errors++; $display("FAIL rnd_lock cyc %0d got %b want %b", i, LOCK, m_lock); end
      checks++; if (INDEX !== 4'(m_index)) begin errors++; $display("FAIL rnd_index cyc %0d got %0d want %0d", i, INDEX, m_index); end
      checks++; if (DIR !== m_dir) begin errors++; $display("FAIL rnd_dir cyc %0d got %b want %b", i, DIR, m_dir); end
      checks++; if (ERR !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", i, ERR, m_err); end
    end
  endtask

  initial begin
    RST = 1'b1; VALID = 1'b0; SYNC = 1'b0; CODE_I = 4'h0;
    test_reset();
    test_acquire();
    test_down();
    test_hold_step();
    test_jump();
    test_illegal();
    test_sync();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_tracker.md
# seq_tracker

Observer-side decoder for the 16-entry up/down code sequence produced by the team's sequence FSM.
- Samples the 4-bit code stream and determines which sequence position (0..15) the producer occupies, plus the direction of the last step.
- Flags any transition the producer cannot legally make, such as a LOAD jump or a corrupted sample.
- Sits at the receiving end of the FSM's DATA_O bus.

## Interface
Parameters: none. The sequence is fixed in the package.

Ports:
- CLK  in  1  rising-edge clock, single domain
- RST  in  1  asynchronous, active-low reset
- VALID  in  1  CODE_I is sampled on this edge
- CODE_I  in  4  code observed on the producer's DATA_O
- SYNC  in  1  discard tracking history (reacquire)
- INDEX  out  4  current position when LOCK=1; holds last locked value otherwise
- LOCK  out  1  exactly one position is consistent with the history
- DIR  out  1  direction of last position change: 1=up, 0=down
- ERR  out  1  one-cycle pulse: sample inconsistent with every candidate
- CAND  out  16  candidate mask, bit p = position p still possible

## Operation
- Sequence SEQ[0..15] = 5,C,0,8,6,8,5,F,9,D,9,E,C,7,F,C. Position 15 wraps to 0.
- Duplicate codes:
  - 5 at {0,6}; C at {1,12,15}; 8 at {3,5}; F at {7,14}; 9 at {8,10}.
  - Unique codes: 0→2, 6→4, D→9, E→11, 7→13.
  - Codes 1,2,3,4,A,B never occur.
- No two adjacent positions share a code, so "hold" (CE=0 on the producer) is distinguishable from a step.
- match[p] = (SEQ[p] == CODE_I).
- On each edge with VALID=1:
  - nxt[p] = match[p] & (CAND[p] | CAND[p-1] | CAND[p+1]), indices mod 16.
  - If nxt ≠ 0: CAND ← nxt.
  - If nxt = 0: ERR pulses; CAND ← match, i.e. reacquire from the current sample. match = 0 for illegal codes, giving CAND = 0.
- CAND = 0 is the "lost" state. The next valid sample is treated as after reset, with CAND ← match.
- SYNC:
  - SYNC=1 with VALID=1: CAND ← match; ERR stays 0.
  - SYNC=1 with VALID=0: CAND ← 16'hFFFF.
  - SYNC has priority over the normal update.
- LOCK = registered "CAND is one-hot".
- INDEX: loaded with the one-hot position whenever the new CAND is one-hot.
- DIR, updated only when the new CAND is one-hot at position q, with old mask O:
  - If O[q]: hold, DIR unchanged.
  - Else if O[q-1]: DIR ← 1.
  - Else if O[q+1]: DIR ← 0.
  - Else (reacquire or jump): DIR unchanged.
  - Priority when several apply: hold > up > down.
- VALID=0 and SYNC=0: all state holds; ERR=0.

## Timing
- Reset (RST=0, asynchronous) sets: CAND=16'hFFFF, LOCK=0, INDEX=0, DIR=1, ERR=0.
- All outputs are registered. Latency is one cycle: the sample on edge N is reflected in the outputs after edge N.
- ERR is high for exactly the one cycle following the offending edge.
- Back-to-back VALID is supported every cycle; there is no backpressure.
- Reset asserted mid-acquisition discards all history immediately. Deassertion is synchronised externally.
- After a producer LOAD jump, the first inconsistent sample raises ERR. LOCK returns at the latest after the samples needed to disambiguate, at most 3 steps.

## Structure
- Package seq_pkg:
  - SEQ constant array (16×4).
  - Function code_match(code) returning the 16-bit match mask.
  - Localparams CAND_ALL=16'hFFFF and SEQ_LEN=16.
- Sub-module seq_onehot_enc: 16-bit mask to 4-bit index plus one-hot flag. Purely combinational; used for INDEX and LOCK.
- Top-level logic: mask update, rotate-neighbour OR, SYNC/ERR priority, DIR decision.

## Test plan
- Reset then samples 5,C,0 (VALID each cycle):
  - CAND = 0x0041, then 0x8002, then 0x0004.
  - LOCK rises after the third sample with INDEX=2, DIR=1.
- Reset then 5,C,F:
  - Lock at INDEX=14, DIR=0.
  - Continue F,7: INDEX=13, DIR=0; no ERR.
- Locked at 2, samples 0,0,8: INDEX stays 2, then becomes 3, DIR=1; no ERR.
- Locked at 2, sample D:
  - ERR pulses for one cycle; CAND=0x0200; INDEX=9; LOCK stays 1; DIR unchanged.
- Locked, sample 0xA (illegal):
  - ERR pulse; CAND=0; LOCK=0.
  - Next sample E: CAND=0x0800, INDEX=11.
- SYNC=1 with VALID=0: CAND=0xFFFF, LOCK=0. Assert RST mid-sequence: all outputs return to reset values on the same cycle.
